// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants for the control pipeline.
// Holds the control vector layout (MSB first) and the EX operand forwarding encodings.
package ctrl_pipe_pkg;

   localparam int CTRL_W     = 11;

   localparam int ALU_OP_HI  = 10;
   localparam int ALU_OP_LO  = 9;
   localparam int ALU_SRC    = 8;
   localparam int MEM_READ   = 7;
   localparam int MEM_WRITE  = 6;
   localparam int MEM_TO_REG = 5;
   localparam int WRITE_EN   = 4;
   localparam int PC_TO_REG  = 3;
   localparam int IS_BRANCH  = 2;
   localparam int IS_JAL     = 1;
   localparam int IS_JALR    = 0;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational stall and EX operand forwarding selects.
// Build option FORWARDING_EN: when defined, results are forwarded from MEM/WB and only
// load-use stalls; when undefined, selects are tied to the regfile and any RAW against
// EX or MEM stalls until the producer reaches WB (regfile is write-before-read).
module hazard_fwd_unit
   import ctrl_pipe_pkg::*;
(
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic       ex_flush_i,
   input  logic       ex_valid_i,
   input  logic       ex_mem_read_i,
   input  logic       ex_we_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] ex_rs1_i,
   input  logic [4:0] ex_rs2_i,
   input  logic       mem_valid_i,
   input  logic       mem_we_i,
   input  logic [4:0] mem_rd_i,
   input  logic       wb_valid_i,
   input  logic       wb_we_i,
   input  logic [4:0] wb_rd_i,
   output logic       stall_o,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   // x0 is never a real producer, so it can neither stall nor forward
   function automatic logic id_reads(input logic [4:0] rd);
      return (rd != 5'd0) &&
             ((id_uses_rs1_i && (id_rs1_i == rd)) || (id_uses_rs2_i && (id_rs2_i == rd)));
   endfunction

   logic hazard;

`ifdef FORWARDING_EN
   function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input logic mem_wr,
                                           input logic wb_wr);
      if (mem_wr && (mem_rd_i != 5'd0) && (mem_rd_i == rs)) return FWD_MEM;
      if (wb_wr && (wb_rd_i != 5'd0) && (wb_rd_i == rs))    return FWD_WB;
      return FWD_RF;
   endfunction

   logic mem_wr;
   logic wb_wr;
   logic unused_ex_we;

   assign mem_wr       = mem_valid_i & mem_we_i;
   assign wb_wr        = wb_valid_i & wb_we_i;
   assign unused_ex_we = ex_we_i;

   // only a load in EX cannot be forwarded in time
   assign hazard  = ex_valid_i & ex_mem_read_i & id_reads(ex_rd_i);
   assign fwd_a_o = fwd_pick(ex_rs1_i, mem_wr, wb_wr);
   assign fwd_b_o = fwd_pick(ex_rs2_i, mem_wr, wb_wr);
`else
   logic unused_fwd_inputs;

   assign unused_fwd_inputs = ^{ex_mem_read_i, ex_rs1_i, ex_rs2_i, wb_valid_i, wb_we_i, wb_rd_i};

   // any pending write in EX or MEM blocks the reader
   assign hazard  = (ex_valid_i & ex_we_i & id_reads(ex_rd_i)) |
                    (mem_valid_i & mem_we_i & id_reads(mem_rd_i));
   assign fwd_a_o = FWD_RF;
   assign fwd_b_o = FWD_RF;
`endif

   assign stall_o = id_valid_i & hazard & ~ex_flush_i;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM, MEM/WB, bubbles on
// flush/stall, and raises a sticky halt when an ecall with x17 == 10 reaches WB.
// Build option FORWARDING_EN selects forwarding vs. full-interlock hazard handling.
module ctrl_pipe #(
   parameter int CTRL_W = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_is_ecall,
   input  logic              id_x17_is_10,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              ex_flush,
   output logic              stall,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [4:0]        ex_rd,
   output logic [4:0]        mem_rd,
   output logic [4:0]        wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              is_halted
);
   import ctrl_pipe_pkg::*;

   logic              ex_valid_q,  ex_valid_d;
   logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
   logic [4:0]        ex_rd_q,     ex_rd_d;
   logic [4:0]        ex_rs1_q,    ex_rs1_d;
   logic [4:0]        ex_rs2_q,    ex_rs2_d;
   logic              ex_halt_q,   ex_halt_d;
   logic              mem_valid_q;
   logic [CTRL_W-1:0] mem_ctrl_q;
   logic [4:0]        mem_rd_q;
   logic              mem_halt_q;
   logic              wb_valid_q;
   logic [CTRL_W-1:0] wb_ctrl_q;
   logic [4:0]        wb_rd_q;
   logic              wb_halt_q;
   logic              halted_q,    halted_d;

   hazard_fwd_unit u_hazard_fwd (
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .ex_flush_i    (ex_flush),
      .ex_valid_i    (ex_valid_q),
      .ex_mem_read_i (ex_ctrl_q[MEM_READ]),
      .ex_we_i       (ex_ctrl_q[WRITE_EN]),
      .ex_rd_i       (ex_rd_q),
      .ex_rs1_i      (ex_rs1_q),
      .ex_rs2_i      (ex_rs2_q),
      .mem_valid_i   (mem_valid_q),
      .mem_we_i      (mem_ctrl_q[WRITE_EN]),
      .mem_rd_i      (mem_rd_q),
      .wb_valid_i    (wb_valid_q),
      .wb_we_i       (wb_ctrl_q[WRITE_EN]),
      .wb_rd_i       (wb_rd_q),
      .stall_o       (stall),
      .fwd_a_o       (fwd_a),
      .fwd_b_o       (fwd_b)
   );

   // ID/EX next state: flush and stall both insert a bubble, otherwise capture ID
   always_comb begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_halt_d  = 1'b0;
      if (!ex_flush && !stall) begin
         ex_valid_d = id_valid;
         ex_ctrl_d  = id_ctrl;
         ex_rd_d    = id_rd;
         ex_rs1_d   = id_rs1;
         ex_rs2_d   = id_rs2;
         ex_halt_d  = id_is_ecall & id_x17_is_10;
      end
   end

   assign halted_d = halted_q | (wb_valid_q & wb_halt_q);

   // stage registers; the back end never stalls so EX/MEM and MEM/WB always advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_rd_q     <= '0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ex_halt_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_ctrl_q  <= '0;
         mem_rd_q    <= '0;
         mem_halt_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_ctrl_q   <= '0;
         wb_rd_q     <= '0;
         wb_halt_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_rd_q     <= ex_rd_d;
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ex_halt_q   <= ex_halt_d;
         mem_valid_q <= ex_valid_q;
         mem_ctrl_q  <= ex_ctrl_q;
         mem_rd_q    <= ex_rd_q;
         mem_halt_q  <= ex_halt_q;
         wb_valid_q  <= mem_valid_q;
         wb_ctrl_q   <= mem_ctrl_q;
         wb_rd_q     <= mem_rd_q;
         wb_halt_q   <= mem_halt_q;
         halted_q    <= halted_d;
      end
   end

   // halt is visible in the same cycle the ecall sits in WB, then held by halted_q
   assign is_halted = halted_d;

   assign ex_ctrl  = ex_valid_q  ? ex_ctrl_q  : '0;
   assign mem_ctrl = mem_valid_q ? mem_ctrl_q : '0;
   assign wb_ctrl  = wb_valid_q  ? wb_ctrl_q  : '0;
   assign ex_rd    = ex_valid_q  ? ex_rd_q    : '0;
   assign mem_rd   = mem_valid_q ? mem_rd_q   : '0;
   assign wb_rd    = wb_valid_q  ? wb_rd_q    : '0;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed hazard/forwarding/flush/halt/reset checks plus a WB scoreboard.
// Expectations follow FORWARDING_EN the same way the design build does.
module tb_ctrl_pipe;
   import ctrl_pipe_pkg::*;

   localparam logic [10:0] C_LW    = 11'h1B0;
   localparam logic [10:0] C_ADD   = 11'h410;
   localparam logic [10:0] C_ADDI  = 11'h510;
   localparam logic [10:0] C_ECALL = 11'h000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid, id_is_ecall, id_x17_is_10, id_uses_rs1, id_uses_rs2, ex_flush;
   logic [10:0] id_ctrl;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        stall, is_halted;
   logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [1:0]  fwd_a, fwd_b;

   typedef struct {
      logic [10:0] ctrl;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_cnt  = 0;
   bit   mon_en   = 1'b0;

   ctrl_pipe #(.CTRL_W(CTRL_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_valid     (id_valid),
      .id_ctrl      (id_ctrl),
      .id_is_ecall  (id_is_ecall),
      .id_x17_is_10 (id_x17_is_10),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_flush     (ex_flush),
      .stall        (stall),
      .ex_ctrl      (ex_ctrl),
      .mem_ctrl     (mem_ctrl),
      .wb_ctrl      (wb_ctrl),
      .ex_rd        (ex_rd),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .is_halted    (is_halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic id_drv(input logic v, input logic [10:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic ecall, input logic x17,
                         input logic flush);
      id_valid     = v;
      id_ctrl      = c;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_is_ecall  = ecall;
      id_x17_is_10 = x17;
      ex_flush     = flush;
   endtask

   task automatic idle();
      id_drv(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // acc: the bench's own judgement that the ID instruction enters EX at this edge
   task automatic step(input logic acc);
      if (acc) sbq.push_back('{ctrl: id_ctrl, rd: id_rd, due: cyc_cnt + 3});
      @(posedge clk);
      #1;
   endtask

   // WB scoreboard: an accepted instruction appears exactly 3 edges after issue
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         if (sbq.size() > 0 && sbq[0].due == cyc_cnt) begin
            chk("wb_ctrl", {21'd0, wb_ctrl}, {21'd0, sbq[0].ctrl});
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, sbq[0].rd});
            void'(sbq.pop_front());
         end else begin
            chk("wb_bubble", {16'd0, wb_ctrl, wb_rd}, 32'd0);
         end
      end
   end

   initial begin
      reset_n = 1'b1;
      idle();
      #1 reset_n = 1'b0;
      #2;
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 0);
      chk("rst_ctrl", {ex_ctrl, mem_ctrl, wb_ctrl}, 0);
      chk("rst_rd", {ex_rd, mem_rd, wb_rd}, 0);
      chk("rst_halt", {31'd0, is_halted}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b0);
      mon_en = 1'b1;

      // producer and consumer of x0
      id_drv(1'b1, C_ADDI, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("x0_prod_stall", {31'd0, stall}, 0);
      step(1'b1);
      id_drv(1'b1, C_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("x0_cons_stall", {31'd0, stall}, 0);
      step(1'b1);
      idle();
      @(negedge clk) chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 0);
      repeat (3) step(1'b0);

      // load-use: lw x5,0(x2) ; add x6,x5,x1
      id_drv(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("lw_stall", {31'd0, stall}, 0);
      step(1'b1);
      id_drv(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("lu_stall", {31'd0, stall}, 1);
      step(1'b0);
      @(negedge clk) chk("lu_bubble_ex", {21'd0, ex_ctrl}, 0);
`ifdef FORWARDING_EN
      chk("lu_stall_end", {31'd0, stall}, 0);
      step(1'b1);
      idle();
      @(negedge clk);
      chk("lu_fwd_a", {30'd0, fwd_a}, 1);
      chk("lu_fwd_b", {30'd0, fwd_b}, 0);
`else
      chk("nf_lu_stall2", {31'd0, stall}, 1);
      step(1'b0);
      @(negedge clk) chk("nf_lu_stall_end", {31'd0, stall}, 0);
      step(1'b1);
      idle();
      @(negedge clk) chk("nf_lu_fwd", {28'd0, fwd_a, fwd_b}, 0);
`endif
      repeat (3) step(1'b0);

      // RAW on x3 from addi x3,x0,7
      id_drv(1'b1, C_ADDI, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("raw_p_stall", {31'd0, stall}, 0);
      step(1'b1);
`ifdef FORWARDING_EN
      id_drv(1'b1, C_ADD, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("raw_c_stall", {31'd0, stall}, 0);
      step(1'b1);
      id_drv(1'b1, C_ADD, 5'd3, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("raw_fwd_a_mem", {30'd0, fwd_a}, 2);
      chk("raw_fwd_b_mem", {30'd0, fwd_b}, 2);
      step(1'b1);
      idle();
      @(negedge clk);
      chk("raw_fwd_a_wb", {30'd0, fwd_a}, 1);
      chk("raw_fwd_b_wb", {30'd0, fwd_b}, 0);
`else
      id_drv(1'b1, C_ADD, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("nf_raw_stall1", {31'd0, stall}, 1);
      step(1'b0);
      @(negedge clk) chk("nf_raw_stall2", {31'd0, stall}, 1);
      step(1'b0);
      @(negedge clk) chk("nf_raw_stall_end", {31'd0, stall}, 0);
      step(1'b1);
      idle();
      @(negedge clk) chk("nf_raw_fwd", {28'd0, fwd_a, fwd_b}, 0);
`endif
      repeat (3) step(1'b0);

      // flush together with a load-use hazard, then a plain flush
      id_drv(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1);
      id_drv(1'b1, C_ADD, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk) chk("flush_stall", {31'd0, stall}, 0);
      step(1'b0);
      id_drv(1'b1, C_ADD, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk) chk("flush_ex_ctrl", {21'd0, ex_ctrl}, 0);
      step(1'b0);
      idle();
      @(negedge clk);
      chk("flush2_ex_ctrl", {21'd0, ex_ctrl}, 0);
      chk("flush2_ex_rd", {27'd0, ex_rd}, 0);
      repeat (3) step(1'b0);

      // ecall that must not halt: x17 != 10, and an invalid slot with x17 == 10
      chk("halt_init", {31'd0, is_halted}, 0);
      id_drv(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1);
      id_drv(1'b0, C_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0);
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) chk("halt_not10", {31'd0, is_halted}, 0);
         step(1'b0);
      end

      // ecall with x17 == 10: halt visible once it reaches WB
      id_drv(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1);
      idle();
      @(negedge clk) chk("halt_c1", {31'd0, is_halted}, 0);
      step(1'b0);
      @(negedge clk) chk("halt_c2", {31'd0, is_halted}, 0);
      step(1'b0);
      @(negedge clk) chk("halt_c3", {31'd0, is_halted}, 1);
      repeat (4) step(1'b0);
      @(negedge clk) chk("halt_sticky", {31'd0, is_halted}, 1);

      // reset mid-stream with work in EX/MEM and a hazard in ID
      id_drv(1'b1, C_ADDI, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1);
      id_drv(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1);
      id_drv(1'b1, C_ADD, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk) chk("pre_rst_stall", {31'd0, stall}, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, stall}, 0);
      chk("mid_rst_fwd", {28'd0, fwd_a, fwd_b}, 0);
      chk("mid_rst_ctrl", {ex_ctrl, mem_ctrl, wb_ctrl}, 0);
      chk("mid_rst_rd", {ex_rd, mem_rd, wb_rd}, 0);
      chk("mid_rst_halt", {31'd0, is_halted}, 0);
      sbq.delete();
      idle();
      step(1'b0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (3) step(1'b0);

      // pipeline runs normally after reset
      id_drv(1'b1, C_ADDI, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1);
      idle();
      @(negedge clk) chk("post_rst_ex_rd", {27'd0, ex_rd}, 3);
      repeat (5) step(1'b0);
      chk("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
